// File: rtl/piso_serializer.sv
// Parallel-in / serial-out shifter with load handshake, per-frame bit order and done pulse.
// Optional trailing even-parity bit when PISO_PARITY_EN is defined.
module piso_serializer #(
  parameter int MSB = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [MSB-1:0] din,
  input  logic           dir,
  input  logic           load_valid,
  output logic           load_ready,
  input  logic           en,
  output logic           dout,
  output logic           dout_valid,
  output logic           done
);

  localparam int CW = (MSB > 1) ? $clog2(MSB) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1
`ifdef PISO_PARITY_EN
    , PARITY = 2'd2
`endif
  } state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic [MSB-1:0] r_shreg;
  logic [CW-1:0]  r_cnt;
  logic           r_dir;
  logic           r_done;
`ifdef PISO_PARITY_EN
  logic           r_parity;
`endif

  logic w_load;
  logic w_shift;
  logic w_last;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latch).
    w_state_next = r_state;
    w_load       = 1'b0;
    w_shift      = 1'b0;
    w_last       = 1'b0;
    load_ready   = 1'b0;
    dout_valid   = 1'b0;
    dout         = 1'b0;

    case (r_state)
      IDLE: begin
        load_ready = 1'b1;
        if (load_valid) begin
          w_load       = 1'b1;
          w_state_next = SHIFT;
        end
      end

      SHIFT: begin
        dout_valid = 1'b1;
        dout       = r_dir ? r_shreg[0] : r_shreg[MSB-1];
        if (en) begin
          w_shift = 1'b1;
          if (r_cnt == CW'(MSB - 1)) begin
`ifdef PISO_PARITY_EN
            w_state_next = PARITY;
`else
            w_state_next = IDLE;
            w_last       = 1'b1;
`endif
          end
        end
      end

`ifdef PISO_PARITY_EN
      PARITY: begin
        dout_valid = 1'b1;
        dout       = r_parity;
        if (en) begin
          w_state_next = IDLE;
          w_last       = 1'b1;
        end
      end
`endif

      default: w_state_next = IDLE;
    endcase
  end

  // Reset wins over load and shift; a frame cut short by reset never raises done.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (rst) begin
      r_state  <= IDLE;
      r_shreg  <= '0;
      r_cnt    <= '0;
      r_dir    <= 1'b0;
      r_done   <= 1'b0;
`ifdef PISO_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      r_state <= w_state_next;
      r_done  <= w_last;
      if (w_load) begin
        r_shreg  <= din;
        r_dir    <= dir;
        r_cnt    <= '0;
`ifdef PISO_PARITY_EN
        r_parity <= ^din;
`endif
      end else if (w_shift) begin
        r_shreg <= r_dir ? {1'b0, r_shreg[MSB-1:1]} : {r_shreg[MSB-2:0], 1'b0};
        r_cnt   <= r_cnt + CW'(1);
      end
    end
  end

  assign done = r_done;

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: stimulus pushes expected frame bits, a negedge monitor pops and compares.
// Honours PISO_PARITY_EN the same way as the design.
module tb_piso_serializer;

  localparam int MSB    = 8;
  localparam int BUDGET = 2000;

  logic           clk = 1'b0;
  logic           rst;
  logic [MSB-1:0] din;
  logic           dir;
  logic           load_valid;
  logic           load_ready;
  logic           en;
  logic           dout;
  logic           dout_valid;
  logic           done;

  piso_serializer #(.MSB(MSB)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .dir        (dir),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .en         (en),
    .dout       (dout),
    .dout_valid (dout_valid),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  exp_t exp_q[$];
  exp_t pend_q[$];
  bit   pend_valid = 1'b0;
  logic exp_done   = 1'b0;
  bit   mon_en     = 1'b0;
  int   n_vec      = 0;
  int   n_err      = 0;

  task automatic check(input string name, input logic act, input logic expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, expv, $time);
    end
  endtask

  // Reference frame: dir=0 sends din[MSB-1] first, dir=1 sends din[0] first, optional even parity last.
  task automatic build_frame(input logic [MSB-1:0] d, input logic dr);
    exp_t e;
    pend_q.delete();
    for (int i = 0; i < MSB; i++) begin
      e.b    = dr ? d[i] : d[MSB-1-i];
      e.last = 1'b0;
      pend_q.push_back(e);
    end
`ifdef PISO_PARITY_EN
    e.b    = ($countones(d) % 2) == 1;
    e.last = 1'b0;
    pend_q.push_back(e);
`endif
    pend_q[pend_q.size()-1].last = 1'b1;
    pend_valid = 1'b1;
  endtask

  // Monitor: compares every cycle, consumes one expected bit per en cycle while a frame is in flight.
  initial begin
    bit   busy;
    logic was_last;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        busy = exp_q.size() != 0;
        check("load_ready", load_ready, !busy);
        check("dout_valid", dout_valid, busy);
        check("done", done, exp_done);
        if (busy) check("dout", dout, exp_q[0].b);
        else      check("dout_idle", dout, 1'b0);
        exp_done = 1'b0;
        if (busy && en) begin
          was_last = exp_q[0].last;
          void'(exp_q.pop_front());
          exp_done = was_last;
        end
      end
    end
  end

  // One clock step; the model follows what the DUT sampled at this edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rst) begin
      exp_q.delete();
      pend_q.delete();
      pend_valid = 1'b0;
      exp_done   = 1'b0;
    end else if (pend_valid) begin
      exp_q      = pend_q;
      pend_valid = 1'b0;
    end
  endtask

  // en_mode 0: en=1 with probability en_pct; en_mode 1: en pattern 1,0,0,1,0,0,...
  task automatic run_frame(input logic [MSB-1:0] d, input logic dr, input int en_pct,
                           input int en_mode, input bit junk, input logic [MSB-1:0] junk_din);
    int k;
    din        = d;
    dir        = dr;
    load_valid = 1'b1;
    en         = 1'($urandom_range(1));
    build_frame(d, dr);
    tick();
    k = 0;
    while ((exp_q.size() != 0) && (k < BUDGET)) begin
      if (en_mode == 1) en = (k % 3) == 0;
      else              en = $urandom_range(99) < en_pct;
      load_valid = junk ? 1'($urandom_range(1)) : 1'b0;
      din        = junk ? junk_din : MSB'($urandom);
      dir        = 1'($urandom_range(1));
      tick();
      k++;
    end
    if (k >= BUDGET) begin
      n_vec++;
      n_err++;
      $display("FAIL timeout: frame %h still in flight after %0d cycles", d, k);
      exp_q.delete();
    end
    load_valid = 1'b0;
    en         = 1'b0;
  endtask

  task automatic reset_mid(input logic [MSB-1:0] d, input int nbits);
    din        = d;
    dir        = 1'b0;
    load_valid = 1'b1;
    en         = 1'b0;
    build_frame(d, 1'b0);
    tick();
    load_valid = 1'b0;
    en         = 1'b1;
    repeat (nbits) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    en  = 1'b0;
    tick();
  endtask

  initial begin
    logic [MSB-1:0] rd;
    rst        = 1'b1;
    din        = '0;
    dir        = 1'b0;
    load_valid = 1'b0;
    en         = 1'b0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    run_frame(8'hB2, 1'b0, 100, 0, 1'b0, '0);
    run_frame(8'hB2, 1'b1, 100, 0, 1'b0, '0);
    run_frame(8'hA5, 1'b0, 0,   1, 1'b0, '0);
    reset_mid(8'hFF, 3);
    run_frame(8'h0F, 1'b0, 100, 0, 1'b0, '0);
    run_frame(8'hC3, 1'b0, 100, 0, 1'b1, 8'h3C);
    run_frame(8'h07, 1'b0, 100, 0, 1'b0, '0);
    run_frame(8'h03, 1'b1, 100, 0, 1'b0, '0);
    run_frame(8'h00, 1'b0, 100, 0, 1'b0, '0);
    run_frame(8'hFF, 1'b1, 100, 0, 1'b0, '0);

    for (int f = 0; f < 40; f++) begin
      rd = MSB'($urandom);
      if ((f % 9) == 8) reset_mid(rd, int'($urandom_range(MSB - 1)));
      else run_frame(rd, 1'($urandom_range(1)), int'($urandom_range(100, 20)), 0,
                     1'($urandom_range(1)), MSB'($urandom));
    end

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
